// File: rtl/pulse_stretcher_pkg.sv
// pulse_stretcher_pkg: FSM state encodings shared by the stretcher and its bench
package pulse_stretcher_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACTIVE  = 2'b01,
    ST_HOLDOFF = 2'b10
  } state_e;
endpackage

// File: rtl/load_down_counter.sv
// load_down_counter: loadable down-counter that stops at zero and flags a count of one
module load_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_one
);
  logic [W-1:0] count_q;
  // Load takes priority over counting; the count saturates at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else if (load) count_q <= load_val;
    else if (en && count_q != '0) count_q <= count_q - W'(1);
  assign count  = count_q;
  assign at_one = count_q == W'(1);
endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches a one-cycle tick into a level of programmable length
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int RETRIGGER = 0,
  parameter int HOLDOFF   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [CNT_W-1:0] len,
  output logic             level,
  output logic             busy,
  output logic             done,
  output logic             dropped
);
  state_e           state_q, state_d;
  logic             p_load, drop_d, level_d, busy_d, done_d;
  logic             level_q, busy_q, done_q, dropped_q;
  logic [CNT_W-1:0] p_count, len_eff;
  logic             p_at_one, h_at_one;
  assign len_eff = (len == '0) ? CNT_W'(1) : len;
  load_down_counter #(.W(CNT_W)) u_pulse_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (p_load),
    .load_val(len_eff),
    .en      (state_q == ST_ACTIVE && p_count != '0),
    .count   (p_count),
    .at_one  (p_at_one)
  );
  if (HOLDOFF > 0) begin : g_ho
    localparam int HW = $clog2(HOLDOFF + 1);
    logic [HW-1:0] h_count;
    logic          h_one;
    load_down_counter #(.W(HW)) u_ho_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (state_q == ST_ACTIVE && state_d == ST_HOLDOFF),
      .load_val(HW'(HOLDOFF)),
      .en      (state_q == ST_HOLDOFF && h_count != '0),
      .count   (h_count),
      .at_one  (h_one)
    );
    assign h_at_one = h_one;
  end else begin : g_no_ho
    assign h_at_one = 1'b1;
  end
  // Next state, counter reload, drop detection and the registered output values
  always_comb begin
    state_d = state_q;
    p_load  = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        p_load  = tick;
        state_d = tick ? ST_ACTIVE : ST_IDLE;
      end
      ST_ACTIVE: begin
        p_load = tick && RETRIGGER != 0;
        drop_d = tick && RETRIGGER == 0;
        if (!p_load && p_at_one) state_d = (HOLDOFF != 0) ? ST_HOLDOFF : ST_IDLE;
      end
      ST_HOLDOFF: begin
        drop_d  = tick;
        state_d = h_at_one ? ST_IDLE : ST_HOLDOFF;
      end
      default: state_d = ST_IDLE;
    endcase
    level_d = state_d == ST_ACTIVE;
    busy_d  = state_d != ST_IDLE;
    done_d  = state_q == ST_ACTIVE && state_d != ST_ACTIVE;
  end
  // State and output registers; reset cuts everything at once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      level_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dropped_q <= drop_d;
    end
  assign level   = level_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign dropped = dropped_q;
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: directed checks of level/busy/done/dropped across three configurations
module tb_pulse_stretcher;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] len;
  logic        tick_a, tick_b, tick_c;
  logic        lv_a, bz_a, dn_a, dr_a;
  logic        lv_b, bz_b, dn_b, dr_b;
  logic        lv_c, bz_c, dn_c, dr_c;
  int          passed = 0, total = 0, fails = 0;
  string       tk;
  logic [3:0]  ex_q[$];

  always #5 clk = ~clk;

  pulse_stretcher u_a (
    .clk(clk), .rst_n(rst_n), .tick(tick_a), .len(len),
    .level(lv_a), .busy(bz_a), .done(dn_a), .dropped(dr_a)
  );
  pulse_stretcher #(.RETRIGGER(1)) u_b (
    .clk(clk), .rst_n(rst_n), .tick(tick_b), .len(len),
    .level(lv_b), .busy(bz_b), .done(dn_b), .dropped(dr_b)
  );
  pulse_stretcher #(.HOLDOFF(0)) u_c (
    .clk(clk), .rst_n(rst_n), .tick(tick_c), .len(len),
    .level(lv_c), .busy(bz_c), .done(dn_c), .dropped(dr_c)
  );

  function automatic logic [3:0] obs(int s);
    return (s == 0) ? {lv_a, bz_a, dn_a, dr_a} :
           (s == 1) ? {lv_b, bz_b, dn_b, dr_b} : {lv_c, bz_c, dn_c, dr_c};
  endfunction

  task automatic chk(string tag, logic [3:0] o, logic [3:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      fails++;
      $error("FAIL %s level/busy/done/dropped observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // tk[i] is the tick driven in relative cycle i; ex_q[i] is expected in cycle i+1
  task automatic run(string tag, int s);
    for (int i = 0; i < ex_q.size(); i++) begin
      tick_a = (s == 0) && (tk[i] == "1");
      tick_b = (s == 1) && (tk[i] == "1");
      tick_c = (s == 2) && (tk[i] == "1");
      step();
      chk($sformatf("%s@%0d", tag, i + 1), obs(s), ex_q[i]);
    end
    tick_a = 1'b0;
    tick_b = 1'b0;
    tick_c = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; len = '0; tick_a = 1'b0; tick_b = 1'b0; tick_c = 1'b0;
    #12;
    chk("reset_a", obs(0), 4'b0000);
    chk("reset_b", obs(1), 4'b0000);
    chk("reset_c", obs(2), 4'b0000);
    rst_n = 1'b1;
    step();
    // len=5: level 5 cycles, done with first holdoff cycle, busy through holdoff
    len = 16'd5;
    tk = "10000000";
    ex_q = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0110, 4'b0100, 4'b0000};
    run("t1_len5", 0);
    // len=0 behaves as a one-cycle pulse
    len = 16'd0;
    tk = "1000";
    ex_q = '{4'b1100, 4'b0110, 4'b0100, 4'b0000};
    run("t2_len0", 0);
    // No retrigger: tick in ACTIVE and in HOLDOFF dropped, tick right after accepted
    len = 16'd4;
    tk = "10100011000000";
    ex_q = '{4'b1100, 4'b1100, 4'b1101, 4'b1100, 4'b0110, 4'b0100, 4'b0001,
             4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0110, 4'b0100, 4'b0000};
    run("t3_drop", 0);
    // Retrigger extends the pulse with a single done and no drop
    len = 16'd4;
    tk = "1001000000";
    ex_q = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100,
             4'b0110, 4'b0100, 4'b0000};
    run("t4_retrig", 1);
    // Async reset mid-pulse, no done afterwards, then a clean 8-cycle pulse
    len = 16'd8;
    tk = "100";
    ex_q = '{4'b1100, 4'b1100, 4'b1100};
    run("t5_pre", 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_cut", obs(0), 4'b0000);
    step();
    chk("t5_in_reset", obs(0), 4'b0000);
    rst_n = 1'b1;
    step();
    chk("t5_no_done", obs(0), 4'b0000);
    tk = "1000000000";
    ex_q = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100,
             4'b0110, 4'b0100};
    run("t5_post", 0);
    // HOLDOFF=0, constant tick, len=3: 1,1,1,0 repeating with done on each gap
    len = 16'd3;
    tk = "11111111111111111111";
    ex_q.delete();
    repeat (5) begin
      ex_q.push_back(4'b1100);
      ex_q.push_back(4'b1101);
      ex_q.push_back(4'b1101);
      ex_q.push_back(4'b0011);
    end
    run("t6_held", 2);
    step();
    chk("t6_idle", obs(2), 4'b0000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
